wdomain: RTL and testbench
==========================

WDOMAIN -- requirements
Module: wdomain

Interface
REQ-001 SHALL have parameter ADDRSIZE, default 4: address width; FIFO depth = 2^ADDRSIZE; legal range >= 2.
REQ-002 SHALL have parameter AFULL_THRESH, default 2^ADDRSIZE-2: fill level at which walmost_full asserts.
REQ-003 SHALL use one clock and a synchronous active-high reset: wclk and wrst.
REQ-004 wclk  input  1  write-domain clock; all state changes on its rising edge.
REQ-005 wrst  input  1  synchronous active-high reset.
REQ-006 winc  input  1  write request from the producer.
REQ-007 wr_rptr  input  ADDRSIZE+1  Gray read pointer, already synchronised into wclk.
REQ-008 waddr  output  ADDRSIZE  memory write address, the low bits of the binary write pointer.
REQ-009 wen  output  1  memory write strobe, combinational = winc & ~wfull.
REQ-010 wptr  output  ADDRSIZE+1  registered Gray write pointer, sent to the read-domain synchroniser.
REQ-011 wfull  output  1  registered full flag.
REQ-012 woverflow  output  1  sticky flag: a write was attempted while full.
REQ-013 wlevel  output  ADDRSIZE+1  registered fill level, range 0..2^ADDRSIZE.
REQ-014 walmost_full  output  1  registered, wlevel >= AFULL_THRESH.

Function
REQ-015 A write SHALL be accepted on a wclk edge when winc=1 and wfull=0; wbin then increments by 1, modulo 2^(ADDRSIZE+1).
REQ-016 wbinnext SHALL be wbin + (winc & ~wfull); wgraynext SHALL be (wbinnext>>1) ^ wbinnext; wbin and wptr SHALL load wbinnext and wgraynext on every non-reset edge.
REQ-017 wfull SHALL register (wgraynext == {~wr_rptr[ADDRSIZE:ADDRSIZE-1], wr_rptr[ADDRSIZE-2:0]}), so it asserts on the same edge that accepts the final free-slot write.
REQ-018 wfull SHALL deassert on the first edge after wr_rptr shows a read, with no extra latency.
REQ-019 While wfull=1: wen=0, wbin, wptr and waddr hold, and winc=1 SHALL set woverflow on that edge.
REQ-020 woverflow SHALL remain 1 until wrst.
REQ-021 The pointer SHALL wrap from binary 2^(ADDRSIZE+1)-1 to 0 with no glitch on full detection; one Gray bit changes per write.
REQ-022 When winc=0, or when winc=1 with wfull=1, the state SHALL be unchanged except woverflow.

Reset
REQ-023 When wrst=1 at a wclk edge, the block SHALL clear wbin, wptr, wfull, woverflow, wlevel and walmost_full to 0.
REQ-024 winc SHALL be ignored in a reset cycle, and no write counts.
REQ-025 wen SHALL be 0 while wfull=0 and winc=0 after reset; it is not otherwise forced by wrst.
REQ-026 Reset mid-operation SHALL discard the pointer with no partial state retained; the read domain must be reset concurrently.

Configuration
REQ-027 Macro WDOMAIN_LEVEL_EN SHALL gate the level logic.
REQ-028 With WDOMAIN_LEVEL_EN defined: rbin_sync is the Gray-to-binary conversion of wr_rptr (XOR prefix from MSB); wlevel registers (wbinnext - rbin_sync) mod 2^(ADDRSIZE+1); walmost_full registers (that value >= AFULL_THRESH).
REQ-029 Without WDOMAIN_LEVEL_EN: wlevel and walmost_full SHALL be tied to constant 0, no converter or subtractor is synthesised, and all other behaviour is identical.

Verification (ADDRSIZE=4, AFULL_THRESH=14, WDOMAIN_LEVEL_EN defined)
REQ-030 Assert wrst for 1 edge with winc=1 -> wptr=0, waddr=0, wfull=0, woverflow=0, wlevel=0.
REQ-031 Hold wr_rptr=0 and do 16 consecutive writes -> after the 14th edge wlevel=14 and walmost_full=1; after the 16th edge wfull=1, wptr=5'b11000, wlevel=16.
REQ-032 Continue from full with winc=1 for 1 edge -> wen=0, wptr stays 5'b11000, woverflow=1 and stays 1.
REQ-033 Set wr_rptr=5'b00001 (one read) -> wfull=0 on the next edge and wlevel=15; a write then refills and sets wfull=1 again.
REQ-034 Run 40 writes with wr_rptr tracking wptr delayed by 2 edges -> wbin wraps 31->0, wfull is never set, and each wptr step changes exactly 1 bit.
REQ-035 Apply wrst=1 at wbin=7 with winc=1 -> all outputs are 0 next edge, and the first write after reset gives waddr=0 then 1.

Source files
------------

// File: rtl/wdomain.sv
// wdomain -- write-side pointer and flag logic of an asynchronous FIFO.
//
// Keeps the binary write pointer, publishes its Gray form to the read domain,
// and derives the full, overflow and (optionally) fill-level flags from the
// read pointer that has already been synchronised into wclk.
//
// Optional feature macro: WDOMAIN_LEVEL_EN
//   defined   -> wlevel / walmost_full are computed from the synchronised
//                read pointer (Gray-to-binary converter plus subtractor).
//   undefined -> wlevel / walmost_full are tied to 0 and no level logic exists.
//
// Ports:
//   wclk          in   write-domain clock, rising edge
//   wrst          in   synchronous active-high reset
//   winc          in   write request from the producer
//   wr_rptr       in   Gray read pointer, synchronised into wclk (ADDRSIZE+1)
//   waddr         out  memory write address = low bits of binary write pointer
//   wen           out  memory write strobe, combinational winc & ~wfull
//   wptr          out  registered Gray write pointer (ADDRSIZE+1)
//   wfull         out  registered full flag
//   woverflow     out  sticky: a write was attempted while full
//   wlevel        out  registered fill level 0..2^ADDRSIZE (ADDRSIZE+1)
//   walmost_full  out  registered, wlevel >= AFULL_THRESH
module wdomain #(
    parameter int ADDRSIZE     = 4,
    parameter int AFULL_THRESH = (1 << ADDRSIZE) - 2
) (
    input  logic                wclk,
    input  logic                wrst,
    input  logic                winc,
    input  logic [ADDRSIZE:0]   wr_rptr,
    output logic [ADDRSIZE-1:0] waddr,
    output logic                wen,
    output logic [ADDRSIZE:0]   wptr,
    output logic                wfull,
    output logic                woverflow,
    output logic [ADDRSIZE:0]   wlevel,
    output logic                walmost_full
);

    logic [ADDRSIZE:0] wbin;
    logic [ADDRSIZE:0] wbinnext;
    logic [ADDRSIZE:0] wgraynext;
    logic              full_next;

    assign wen       = winc & ~wfull;
    assign waddr     = wbin[ADDRSIZE-1:0];
    assign wbinnext  = wbin + {{ADDRSIZE{1'b0}}, wen};
    assign wgraynext = (wbinnext >> 1) ^ wbinnext;

    // The FIFO is full when the next write pointer has lapped the read
    // pointer exactly once: in Gray code that is the top two bits inverted
    // and the rest equal. Comparing against wgraynext (not wptr) makes wfull
    // rise on the same edge that takes the last free slot.
    assign full_next = (wgraynext == {~wr_rptr[ADDRSIZE:ADDRSIZE-1],
                                      wr_rptr[ADDRSIZE-2:0]});

    always_ff @(posedge wclk) begin
        if (wrst) begin
            wbin      <= '0;
            wptr      <= '0;
            wfull     <= 1'b0;
            woverflow <= 1'b0;
        end else begin
            wbin  <= wbinnext;
            wptr  <= wgraynext;
            wfull <= full_next;
            if (winc && wfull) begin
                woverflow <= 1'b1;
            end
        end
    end

`ifdef WDOMAIN_LEVEL_EN
    localparam logic [ADDRSIZE:0] AFULL_LVL = (ADDRSIZE + 1)'(AFULL_THRESH);

    logic [ADDRSIZE:0] rbin_sync;
    logic [ADDRSIZE:0] level_next;

    // Gray to binary: each binary bit is the XOR of all Gray bits at or
    // above it.
    always_comb begin
        rbin_sync = '0;
        for (int i = 0; i <= ADDRSIZE; i++) begin
            rbin_sync[i] = ^(wr_rptr >> i);
        end
    end

    // Modulo subtraction of the extended pointers gives 0..2^ADDRSIZE.
    assign level_next = wbinnext - rbin_sync;

    always_ff @(posedge wclk) begin
        if (wrst) begin
            wlevel       <= '0;
            walmost_full <= 1'b0;
        end else begin
            wlevel       <= level_next;
            walmost_full <= (level_next >= AFULL_LVL);
        end
    end
`else
    assign wlevel       = '0;
    assign walmost_full = 1'b0;
`endif

endmodule

// File: tb/tb_wdomain.sv
// Testbench for wdomain (ADDRSIZE=4, AFULL_THRESH=14).
// Level outputs are expected to follow the occupancy only when the build
// defines WDOMAIN_LEVEL_EN; otherwise they are expected to stay 0.
module tb_wdomain;

    localparam int AS    = 4;
    localparam int DEPTH = 1 << AS;
    localparam int AFT   = 14;
`ifdef WDOMAIN_LEVEL_EN
    localparam bit LVL_ON = 1'b1;
`else
    localparam bit LVL_ON = 1'b0;
`endif

    logic          wclk = 1'b0;
    logic          wrst = 1'b1;
    logic          winc = 1'b0;
    logic [AS:0]   wr_rptr = '0;
    logic [AS-1:0] waddr;
    logic          wen;
    logic [AS:0]   wptr;
    logic          wfull;
    logic          woverflow;
    logic [AS:0]   wlevel;
    logic          walmost_full;

    wdomain #(.ADDRSIZE(AS), .AFULL_THRESH(AFT)) dut (
        .wclk(wclk), .wrst(wrst), .winc(winc), .wr_rptr(wr_rptr),
        .waddr(waddr), .wen(wen), .wptr(wptr), .wfull(wfull),
        .woverflow(woverflow), .wlevel(wlevel), .walmost_full(walmost_full)
    );

    always #5 wclk = ~wclk;

    int nchk = 0;
    int nerr = 0;

    // Reference model: plain counts of writes and reads since reset.
    int m_w = 0;
    int m_r = 0;
    bit m_full = 1'b0;
    bit m_ovf = 1'b0;

    typedef struct {
        bit          rst;
        bit          inc;
        int          rc;
        bit          e_wen;
        logic [AS:0] e_wptr;
        int          e_waddr;
        bit          e_full;
        bit          e_ovf;
        int          e_lvl;
        bit          e_af;
    } vec_t;

    vec_t tbl[21];

    function automatic logic [AS:0] gray(input int n);
        logic [AS:0] b;
        b = n[AS:0];
        return (b >> 1) ^ b;
    endfunction

    task automatic chk(input string nm, input int got, input int exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // One clock: drive at the falling edge, sample wen 1 ns later (it is
    // combinational), then let the rising edge happen and settle 1 ns.
    task automatic cyc(input bit rst, input bit inc, input int rc, output bit wen_s);
        @(negedge wclk);
        wrst    = rst;
        winc    = inc;
        wr_rptr = gray(rc);
        #1;
        wen_s = wen;
        @(posedge wclk);
        #1;
    endtask

    task automatic mstep(input bit rst, input bit inc, input int rc);
        bit ws;
        int lvl;
        chk("wen", 0, 0);
        nchk--;
        cyc(rst, inc, rc, ws);
        if (!rst) chk("wen", ws, (inc && !m_full) ? 1 : 0);
        if (rst) begin
            m_w = 0; m_r = 0; m_full = 1'b0; m_ovf = 1'b0;
        end else begin
            if (inc && m_full) m_ovf = 1'b1;
            else if (inc) m_w++;
            m_r    = rc;
            m_full = ((m_w - m_r) == DEPTH);
        end
        lvl = m_w - m_r;
        chk("wptr", wptr, gray(m_w));
        chk("waddr", waddr, m_w % DEPTH);
        chk("wfull", wfull, m_full);
        chk("woverflow", woverflow, m_ovf);
        chk("wlevel", wlevel, LVL_ON ? lvl : 0);
        chk("walmost_full", walmost_full, (LVL_ON && lvl >= AFT) ? 1 : 0);
    endtask

    initial begin
        bit ws;
        int rc;
        int rdp;
        int h1;
        int h2;
        logic [AS:0] prev;

        // Directed vectors: reset with winc=1, 16 writes to full, an
        // overflow attempt, one read, a refill, and a hold while full.
        tbl[0] = '{1'b1, 1'b1, 0, 1'b1, 5'd0, 0, 1'b0, 1'b0, 0, 1'b0};
        for (int i = 1; i <= 16; i++) begin
            tbl[i] = '{1'b0, 1'b1, 0, 1'b1, gray(i), i % 16, (i == 16), 1'b0, i, (i >= AFT)};
        end
        tbl[17] = '{1'b0, 1'b1, 0, 1'b0, 5'b11000, 0, 1'b1, 1'b1, 16, 1'b1};
        tbl[18] = '{1'b0, 1'b0, 1, 1'b0, 5'b11000, 0, 1'b0, 1'b1, 15, 1'b1};
        tbl[19] = '{1'b0, 1'b1, 1, 1'b1, 5'b11001, 1, 1'b1, 1'b1, 16, 1'b1};
        tbl[20] = '{1'b0, 1'b0, 1, 1'b0, 5'b11001, 1, 1'b1, 1'b1, 16, 1'b1};

        cyc(1'b1, 1'b0, 0, ws);

        for (int i = 0; i < 21; i++) begin
            cyc(tbl[i].rst, tbl[i].inc, tbl[i].rc, ws);
            chk($sformatf("v%0d_wen", i), ws, tbl[i].e_wen);
            chk($sformatf("v%0d_wptr", i), wptr, tbl[i].e_wptr);
            chk($sformatf("v%0d_waddr", i), waddr, tbl[i].e_waddr);
            chk($sformatf("v%0d_wfull", i), wfull, tbl[i].e_full);
            chk($sformatf("v%0d_woverflow", i), woverflow, tbl[i].e_ovf);
            chk($sformatf("v%0d_wlevel", i), wlevel, LVL_ON ? tbl[i].e_lvl : 0);
            chk($sformatf("v%0d_walmost", i), walmost_full, LVL_ON ? tbl[i].e_af : 1'b0);
        end

        // Reads trailing writes by two edges: pointer wraps, never full,
        // and every step of wptr flips a single bit.
        mstep(1'b1, 1'b0, 0);
        h1 = 0; h2 = 0;
        prev = gray(0);
        for (int i = 0; i < 40; i++) begin
            rc = h2;
            mstep(1'b0, 1'b1, rc);
            h2 = h1; h1 = m_w;
            chk("trail_full", wfull, 0);
            chk("gray_step", $countones(wptr ^ prev), 1);
            prev = gray(m_w);
        end
        chk("wrap_wptr", wptr, gray(40));

        // Reset in the middle of operation with a write pending.
        mstep(1'b1, 1'b0, 0);
        for (int i = 0; i < 7; i++) mstep(1'b0, 1'b1, 0);
        mstep(1'b1, 1'b1, 0);
        chk("rst_waddr", waddr, 0);
        mstep(1'b0, 1'b1, 0);
        chk("post_rst_waddr", waddr, 1);

        // Randomised traffic with alternating fill/drain bias.
        mstep(1'b1, 1'b0, 0);
        for (int i = 0; i < 800; i++) begin
            rdp = ((i / 64) % 2 == 0) ? 20 : 75;
            if ($urandom_range(0, 199) == 0) begin
                mstep(1'b1, $urandom_range(0, 1), 0);
            end else begin
                rc = m_r;
                if (rc < m_w && $urandom_range(0, 99) < rdp) rc++;
                mstep(1'b0, ($urandom_range(0, 99) < 70), rc);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
